// File: rtl/gem5_proto_pkg.sv
// rtl/gem5_proto_pkg.sv - shared constants for the accelerator read/write streaming protocol
package gem5_proto_pkg;

    // Responder FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD_LAT = 3'd1;
    localparam logic [2:0] ST_RD_ACK = 3'd2;
    localparam logic [2:0] ST_WR_LAT = 3'd3;
    localparam logic [2:0] ST_WR_ACK = 3'd4;

    // The ready lines are 64 bits wide on the wire but only ever carry 0 or 1
    localparam logic [63:0] READY     = 64'd1;
    localparam logic [63:0] NOT_READY = 64'd0;

    localparam int WORD_BYTES = 4;

    localparam int DEF_RD_LAT = 4;
    localparam int DEF_WR_LAT = 2;

endpackage

// File: rtl/resp_mem.sv
// rtl/resp_mem.sv - dual-port synchronous 32-bit RAM, port A protocol, port B backdoor
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset (read registers only)
//   a_addr/a_we/a_wdata port A write; a_rdata registered read, write-first
//   b_en/b_we/b_addr    port B access; b_wdata write data
//   b_rdata             port B registered read, returns pre-write contents
module resp_mem #(
    parameter int ADDR_WID = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_WID-1:0] a_addr,
    input  logic                a_we,
    input  logic [31:0]         a_wdata,
    output logic [31:0]         a_rdata,
    input  logic                b_en,
    input  logic                b_we,
    input  logic [ADDR_WID-1:0] b_addr,
    input  logic [31:0]         b_wdata,
    output logic [31:0]         b_rdata
);

    logic [31:0] mem [0:(1 << ADDR_WID) - 1];

    // Port A is written last so a same-word collision keeps the protocol data
    always_ff @(posedge clk) begin
        if (b_en && b_we) begin
            mem[b_addr] <= b_wdata;
        end
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_rdata <= 32'h0;
            b_rdata <= 32'h0;
        end else begin
            a_rdata <= a_we ? a_wdata : mem[a_addr];
            if (b_en) begin
                b_rdata <= mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/gem5_mem_responder.sv
// rtl/gem5_mem_responder.sv - memory-side responder for the beat-by-beat read/write streaming protocol
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   read_enable/read_addr/read_size_output/finish_read   read session from the initiator
//   read_ready/read_data             one-cycle beat pulse and beat data
//   write_enable/write_addr/write_size/write_data/finish_write   write session
//   write_ready                      one-cycle pulse per accepted write beat
//   bd_en/bd_we/bd_addr/bd_wdata/bd_rdata   backdoor memory port, 1-cycle read latency
//   err                              sticky: bad address or beat size seen
//   rd_beats/wr_beats                served beat counters
module gem5_mem_responder
    import gem5_proto_pkg::*;
#(
    parameter int          MEM_ADDR_WID = 14,
    parameter logic [63:0] BASE_ADDR    = 64'h0,
    parameter int          RD_LAT       = DEF_RD_LAT,
    parameter int          WR_LAT       = DEF_WR_LAT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    read_enable,
    input  logic [63:0]             read_addr,
    input  logic [63:0]             read_size_output,
    input  logic                    finish_read,
    output logic [63:0]             read_ready,
    output logic [31:0]             read_data,
    input  logic                    write_enable,
    input  logic [63:0]             write_addr,
    input  logic [63:0]             write_size,
    input  logic [31:0]             write_data,
    input  logic                    finish_write,
    output logic [63:0]             write_ready,
    input  logic                    bd_en,
    input  logic                    bd_we,
    input  logic [MEM_ADDR_WID-1:0] bd_addr,
    input  logic [31:0]             bd_wdata,
    output logic [31:0]             bd_rdata,
    output logic                    err,
    output logic [31:0]             rd_beats,
    output logic [31:0]             wr_beats
);

    localparam logic [63:0] MEM_BYTES = 64'(WORD_BYTES) << MEM_ADDR_WID;
    localparam logic [7:0]  RD_CNT    = 8'(RD_LAT - 1);
    localparam logic [7:0]  WR_CNT    = 8'(WR_LAT - 1);

    // Offset comparison avoids overflow of BASE_ADDR + MEM_BYTES near the top of the map
    function automatic logic addr_ok(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off < MEM_BYTES) && (off[1:0] == 2'b00);
    endfunction

    function automatic logic [MEM_ADDR_WID-1:0] addr_idx(input logic [63:0] a);
        return MEM_ADDR_WID'((a - BASE_ADDR) >> 2);
    endfunction

    logic [2:0]              state;
    logic [7:0]              cnt;
    logic [MEM_ADDR_WID-1:0] idx_q;
    logic                    ok_q;
    logic [1:0]              rst_sync;
    logic [31:0]             mem_rdata;
    logic [MEM_ADDR_WID-1:0] mem_addr;
    logic                    mem_we;
    logic                    rd_ok_in;
    logic                    rd_bad_in;
    logic                    wr_ok_in;
    logic                    wr_bad_in;

    assign rd_ok_in  = addr_ok(read_addr);
    assign rd_bad_in = !rd_ok_in || (read_size_output != 64'(WORD_BYTES));
    assign wr_ok_in  = addr_ok(write_addr);
    assign wr_bad_in = !wr_ok_in || (write_size != 64'(WORD_BYTES));

    // Outside the latency states the RAM is pointed at the incoming read address,
    // so the registered read data is already valid when RD_LAT is 1.
    assign mem_addr = ((state == ST_RD_LAT) || (state == ST_WR_LAT)) ? idx_q : addr_idx(read_addr);
    assign mem_we   = (state == ST_WR_LAT) && write_enable && (cnt == 8'd0) && ok_q;

    // Reset assertion is immediate; release is held off two edges before new sessions start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            idx_q       <= '0;
            ok_q        <= 1'b0;
            read_ready  <= NOT_READY;
            write_ready <= NOT_READY;
            read_data   <= 32'h0;
            err         <= 1'b0;
            rd_beats    <= 32'd0;
            wr_beats    <= 32'd0;
        end else begin
            read_ready  <= NOT_READY;
            write_ready <= NOT_READY;
            case (state)
                ST_IDLE: begin
                    if (rst_sync[1]) begin
                        if (read_enable) begin
                            state <= ST_RD_LAT;
                            cnt   <= RD_CNT;
                            idx_q <= addr_idx(read_addr);
                            ok_q  <= rd_ok_in;
                            err   <= err | rd_bad_in;
                        end else if (write_enable) begin
                            state <= ST_WR_LAT;
                            cnt   <= WR_CNT;
                            idx_q <= addr_idx(write_addr);
                            ok_q  <= wr_ok_in;
                            err   <= err | wr_bad_in;
                        end
                    end
                end
                ST_RD_LAT: begin
                    if (!read_enable) begin
                        state <= ST_IDLE;
                    end else if (cnt == 8'd0) begin
                        read_data  <= ok_q ? mem_rdata : 32'h0;
                        read_ready <= READY;
                        rd_beats   <= rd_beats + 32'd1;
                        state      <= ST_RD_ACK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_RD_ACK: begin
                    if (!read_enable) begin
                        state <= ST_IDLE;
                    end else if (finish_read) begin
                        state <= ST_RD_LAT;
                        cnt   <= RD_CNT;
                        idx_q <= addr_idx(read_addr);
                        ok_q  <= rd_ok_in;
                        err   <= err | rd_bad_in;
                    end
                end
                ST_WR_LAT: begin
                    if (!write_enable) begin
                        state <= ST_IDLE;
                    end else if (cnt == 8'd0) begin
                        write_ready <= READY;
                        wr_beats    <= wr_beats + 32'd1;
                        state       <= ST_WR_ACK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_WR_ACK: begin
                    if (!write_enable) begin
                        state <= ST_IDLE;
                    end else if (finish_write) begin
                        state <= ST_WR_LAT;
                        cnt   <= WR_CNT;
                        idx_q <= addr_idx(write_addr);
                        ok_q  <= wr_ok_in;
                        err   <= err | wr_bad_in;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    resp_mem #(.ADDR_WID(MEM_ADDR_WID)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .a_addr  (mem_addr),
        .a_we    (mem_we),
        .a_wdata (write_data),
        .a_rdata (mem_rdata),
        .b_en    (bd_en),
        .b_we    (bd_we),
        .b_addr  (bd_addr),
        .b_wdata (bd_wdata),
        .b_rdata (bd_rdata)
    );

endmodule

// File: tb/tb_gem5_mem_responder.sv
// tb/tb_gem5_mem_responder.sv - scoreboard bench for gem5_mem_responder
module tb_gem5_mem_responder;

    localparam logic [63:0] BASE0 = 64'h1000;

    typedef struct {
        int          d;
        logic [31:0] data;
        int          period;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_enable [2];
    logic [63:0] read_addr [2];
    logic [63:0] read_size_output [2];
    logic        finish_read [2];
    logic [63:0] read_ready [2];
    logic [31:0] read_data [2];
    logic        write_enable [2];
    logic [63:0] write_addr [2];
    logic [63:0] write_size [2];
    logic [31:0] write_data [2];
    logic        finish_write [2];
    logic [63:0] write_ready [2];
    logic        bd_en [2];
    logic        bd_we [2];
    logic [13:0] bd_addr [2];
    logic [31:0] bd_wdata [2];
    logic [31:0] bd_rdata [2];
    logic        err [2];
    logic [31:0] rd_beats [2];
    logic [31:0] wr_beats [2];

    logic        bd_rv [2];
    logic        prev_rr [2];
    int          last_rd [2];
    int          last_wr [2];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        rd_q[$];
    exp_t        wr_q[$];
    exp_t        bd_q[$];
    exp_t        me;

    always #5 clk = ~clk;

    gem5_mem_responder #(.MEM_ADDR_WID(14), .BASE_ADDR(BASE0), .RD_LAT(4), .WR_LAT(2)) u_dut0 (
        .clk(clk), .reset(reset),
        .read_enable(read_enable[0]), .read_addr(read_addr[0]), .read_size_output(read_size_output[0]),
        .finish_read(finish_read[0]), .read_ready(read_ready[0]), .read_data(read_data[0]),
        .write_enable(write_enable[0]), .write_addr(write_addr[0]), .write_size(write_size[0]),
        .write_data(write_data[0]), .finish_write(finish_write[0]), .write_ready(write_ready[0]),
        .bd_en(bd_en[0]), .bd_we(bd_we[0]), .bd_addr(bd_addr[0]), .bd_wdata(bd_wdata[0]),
        .bd_rdata(bd_rdata[0]), .err(err[0]), .rd_beats(rd_beats[0]), .wr_beats(wr_beats[0])
    );

    gem5_mem_responder #(.MEM_ADDR_WID(14), .BASE_ADDR(64'h0), .RD_LAT(1), .WR_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .read_enable(read_enable[1]), .read_addr(read_addr[1]), .read_size_output(read_size_output[1]),
        .finish_read(finish_read[1]), .read_ready(read_ready[1]), .read_data(read_data[1]),
        .write_enable(write_enable[1]), .write_addr(write_addr[1]), .write_size(write_size[1]),
        .write_data(write_data[1]), .finish_write(finish_write[1]), .write_ready(write_ready[1]),
        .bd_en(bd_en[1]), .bd_we(bd_we[1]), .bd_addr(bd_addr[1]), .bd_wdata(bd_wdata[1]),
        .bd_rdata(bd_rdata[1]), .err(err[1]), .rd_beats(rd_beats[1]), .wr_beats(wr_beats[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // kind: 0 read beat, 1 write beat, 2 backdoor read
    task automatic exp_push(input int kind, input int d, input logic [31:0] data, input int period);
        exp_t e;
        e.d = d;
        e.data = data;
        e.period = period;
        case (kind)
            0: rd_q.push_back(e);
            1: wr_q.push_back(e);
            default: bd_q.push_back(e);
        endcase
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bd_rv[0] <= bd_en[0] & ~bd_we[0];
        bd_rv[1] <= bd_en[1] & ~bd_we[1];
    end

    // Monitor: every output event is matched against the scoreboard queues
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (read_ready[d] != 64'd0) begin
                chk("rd_ready_value", read_ready[d], 64'd1);
                chk("rd_ready_back_to_back", 64'(prev_rr[d]), 64'd0);
                chk("rd_pulse_expected", 64'(rd_q.size() != 0), 64'd1);
                if (rd_q.size() != 0) begin
                    me = rd_q.pop_front();
                    chk("rd_dut", 64'(d), 64'(me.d));
                    chk("rd_data", 64'(read_data[d]), 64'(me.data));
                    if (me.period != 0) chk("rd_period", 64'(cyc - last_rd[d]), 64'(me.period));
                end
                last_rd[d] = cyc;
            end
            prev_rr[d] = (read_ready[d] != 64'd0);
            if (write_ready[d] != 64'd0) begin
                chk("wr_ready_value", write_ready[d], 64'd1);
                chk("wr_pulse_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    me = wr_q.pop_front();
                    chk("wr_dut", 64'(d), 64'(me.d));
                    if (me.period != 0) chk("wr_period", 64'(cyc - last_wr[d]), 64'(me.period));
                end
                last_wr[d] = cyc;
            end
            if (bd_rv[d]) begin
                chk("bd_read_expected", 64'(bd_q.size() != 0), 64'd1);
                if (bd_q.size() != 0) begin
                    me = bd_q.pop_front();
                    chk("bd_rdata", 64'(bd_rdata[d]), 64'(me.data));
                end
            end
        end
    end

    task automatic wait_pulse(input int d, input bit wr);
        int k;
        for (k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (wr ? write_ready[d][0] : read_ready[d][0]) break;
        end
        chk(wr ? "wr_pulse_timeout" : "rd_pulse_timeout", 64'(k < 40), 64'd1);
    endtask

    task automatic bd_wr(input int d, input int a, input logic [31:0] v);
        bd_en[d] = 1'b1; bd_we[d] = 1'b1; bd_addr[d] = 14'(a); bd_wdata[d] = v;
        @(posedge clk); #1;
        bd_en[d] = 1'b0; bd_we[d] = 1'b0;
    endtask

    task automatic bd_rd(input int d, input int a, input logic [31:0] v);
        exp_push(2, d, v, 0);
        bd_en[d] = 1'b1; bd_we[d] = 1'b0; bd_addr[d] = 14'(a);
        @(posedge clk); #1;
        bd_en[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    // Initiator: takes each beat one cycle after seeing read_ready
    task automatic rd_session(input int d, input logic [63:0] a, input int n);
        read_addr[d] = a;
        read_enable[d] = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_pulse(d, 1'b0);
            @(posedge clk); #1;
            if (i < n - 1) begin
                finish_read[d] = 1'b1;
                read_addr[d] = read_addr[d] + 64'd4;
                @(posedge clk); #1;
                finish_read[d] = 1'b0;
            end else begin
                read_enable[d] = 1'b0;
            end
        end
    endtask

    task automatic wr_session(input int d, input logic [63:0] a, input int n, input logic [31:0] v0);
        write_addr[d] = a;
        write_data[d] = v0;
        write_enable[d] = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_pulse(d, 1'b1);
            @(posedge clk); #1;
            if (i < n - 1) begin
                finish_write[d] = 1'b1;
                write_addr[d] = write_addr[d] + 64'd4;
                write_data[d] = write_data[d] + 32'd1;
                @(posedge clk); #1;
                finish_write[d] = 1'b0;
            end else begin
                write_enable[d] = 1'b0;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            read_enable[d] = 1'b0; read_addr[d] = 64'h0; read_size_output[d] = 64'd4; finish_read[d] = 1'b0;
            write_enable[d] = 1'b0; write_addr[d] = 64'h0; write_size[d] = 64'd4; write_data[d] = 32'h0;
            finish_write[d] = 1'b0; bd_en[d] = 1'b0; bd_we[d] = 1'b0; bd_addr[d] = 14'h0; bd_wdata[d] = 32'h0;
            prev_rr[d] = 1'b0; last_rd[d] = 0; last_wr[d] = 0;
        end
        repeat (3) @(posedge clk); #1;
        chk("rst_read_ready", read_ready[0], 64'd0);
        chk("rst_write_ready", write_ready[0], 64'd0);
        chk("rst_read_data", 64'(read_data[0]), 64'd0);
        chk("rst_bd_rdata", 64'(bd_rdata[0]), 64'd0);
        chk("rst_err", 64'(err[0]), 64'd0);
        chk("rst_rd_beats", 64'(rd_beats[0]), 64'd0);
        chk("rst_wr_beats", 64'(wr_beats[0]), 64'd0);
        reset = 1'b1;

        // Preload and 16-beat read session
        bd_wr(0, 14'h3FFF, 32'h77);
        for (int i = 0; i < 16; i++) bd_wr(0, i, 32'(i * 3));
        for (int i = 0; i < 16; i++) exp_push(0, 0, 32'(i * 3), (i == 0) ? 0 : 6);
        rd_session(0, BASE0, 16);
        chk("rd_beats_16", 64'(rd_beats[0]), 64'd16);

        // 8-beat write session at BASE+0x40 (words 16..23)
        for (int i = 0; i < 8; i++) exp_push(1, 0, 32'h0, (i == 0) ? 0 : 4);
        wr_session(0, BASE0 + 64'h40, 8, 32'hA000_0000);
        for (int i = 0; i < 8; i++) bd_rd(0, 16 + i, 32'hA000_0000 + 32'(i));
        chk("wr_beats_8", 64'(wr_beats[0]), 64'd8);
        chk("err_clean", 64'(err[0]), 64'd0);

        // Read and write requested in the same cycle: read goes first
        read_addr[0] = BASE0 + 64'h4;
        write_addr[0] = BASE0 + 64'h60;
        write_data[0] = 32'h5555;
        exp_push(0, 0, 32'd3, 0);
        read_enable[0] = 1'b1;
        write_enable[0] = 1'b1;
        wait_pulse(0, 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("write_held_off", 64'(wr_beats[0]), 64'd8);
        exp_push(1, 0, 32'h0, 0);
        read_enable[0] = 1'b0;
        wait_pulse(0, 1'b1);
        @(posedge clk); #1;
        write_enable[0] = 1'b0;
        bd_rd(0, 24, 32'h5555);
        chk("err_after_collide", 64'(err[0]), 64'd0);

        // Out-of-range read below BASE and write past the top
        exp_push(0, 0, 32'h0, 0);
        rd_session(0, BASE0 - 64'd4, 1);
        exp_push(1, 0, 32'h0, 0);
        wr_session(0, BASE0 + 64'h10000, 1, 32'hDEAD);
        chk("err_set", 64'(err[0]), 64'd1);
        bd_rd(0, 0, 32'h0);
        bd_rd(0, 14'h3FFF, 32'h77);
        chk("rd_beats_err", 64'(rd_beats[0]), 64'd18);
        chk("wr_beats_err", 64'(wr_beats[0]), 64'd10);

        // Reset in the middle of a read latency
        exp_push(0, 0, 32'd6, 0);
        rd_session(0, BASE0 + 64'h8, 1);
        chk("rd_data_hold", 64'(read_data[0]), 64'd6);
        read_addr[0] = BASE0 + 64'h4;
        read_enable[0] = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midrst_read_ready", read_ready[0], 64'd0);
        chk("midrst_read_data", 64'(read_data[0]), 64'd0);
        chk("midrst_err", 64'(err[0]), 64'd0);
        chk("midrst_rd_beats", 64'(rd_beats[0]), 64'd0);
        chk("midrst_wr_beats", 64'(wr_beats[0]), 64'd0);
        read_enable[0] = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        exp_push(0, 0, 32'd15, 0);
        exp_push(0, 0, 32'd18, 6);
        rd_session(0, BASE0 + 64'd20, 2);
        chk("post_rst_rd_beats", 64'(rd_beats[0]), 64'd2);
        bd_rd(0, 20, 32'hA000_0004);

        // Minimum latency instance: 3 cycles per beat
        for (int i = 0; i < 4; i++) bd_wr(1, i, 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) exp_push(0, 1, 32'h100 + 32'(i), (i == 0) ? 0 : 3);
        rd_session(1, 64'h0, 4);
        for (int i = 0; i < 3; i++) exp_push(1, 1, 32'h0, (i == 0) ? 0 : 3);
        wr_session(1, 64'd32, 3, 32'hB0);
        for (int i = 0; i < 3; i++) bd_rd(1, 8 + i, 32'hB0 + 32'(i));
        chk("l1_rd_beats", 64'(rd_beats[1]), 64'd4);
        chk("l1_wr_beats", 64'(wr_beats[1]), 64'd3);
        chk("l1_err_clean", 64'(err[1]), 64'd0);

        // Bad beat size is flagged but still served as a word
        read_size_output[1] = 64'd8;
        exp_push(0, 1, 32'h100, 0);
        rd_session(1, 64'h0, 1);
        read_size_output[1] = 64'd4;
        chk("l1_err_size", 64'(err[1]), 64'd1);

        repeat (3) @(posedge clk); #1;
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        chk("bd_q_drained", 64'(bd_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
